teller_dispatcher: RTL
======================

TELLER_DISPATCHER -- requirements
Module: teller_dispatcher

Interface
REQ-001 Parameter NUM_TELLERS, default 3, number of teller desks; the fixed maximum.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, cycles a called customer has to pass the front sensor.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Tcount  input  2  number of active tellers (1..3); teller i is eligible only when i < Tcount.
REQ-006 emptyFlag  input  1  queue empty indication from the queue manager.
REQ-007 tellerDone  input  3  one-cycle pulse per teller: customer finished, desk free again.
REQ-008 frontSensor  input  1  raw front sensor level, already synchronous to clk; high while a customer passes.
REQ-009 downSignal  output  1  one-cycle pulse to the queue counter: one customer left the queue.
REQ-010 callValid  output  1  high while a call is displayed.
REQ-011 callTeller  output  2  called desk number 1..3; 0 when no call.
REQ-012 ticketNo  output  5  running ticket number of the current call.
REQ-013 noShow  output  1  one-cycle pulse when a call times out.
REQ-014 tellerBusy  output  3  per-teller busy bits.

Function
REQ-015 The FSM SHALL have states IDLE, CALL, and a one-cycle RELEASE state.
REQ-016 In IDLE, when emptyFlag=0, Tcount!=0, and at least one eligible teller is not busy, the FSM SHALL select one teller round-robin, starting after the last dispatched index, and enter CALL on the next edge.
REQ-017 On entering CALL, the block SHALL set callValid=1 and callTeller=index+1, set the selected tellerBusy bit, and increment ticketNo in the same cycle.
REQ-018 ticketNo SHALL be 5 bits and wrap from 31 to 0; the first call after reset shows 1.
REQ-019 In CALL, a rising edge of frontSensor (level high now, low the previous cycle) SHALL cause downSignal=1 for exactly the next cycle and a transition to RELEASE.
REQ-020 In CALL, after TIMEOUT_CYCLES cycles without such an edge, the block SHALL pulse noShow and downSignal together for one cycle, clear the called teller's busy bit, and go to RELEASE.
REQ-021 In CALL, if emptyFlag becomes 1, the block SHALL return to IDLE with no downSignal pulse and clear the called teller's busy bit.
REQ-022 RELEASE SHALL clear callValid and set callTeller=0 for one cycle, then return to IDLE; no dispatch occurs in RELEASE.
REQ-023 tellerDone[i] SHALL clear tellerBusy[i], except while teller i is the currently called teller, when it is ignored; tellerDone on a free teller has no effect.
REQ-024 Frontsensor edges outside CALL SHALL be ignored and SHALL NOT produce downSignal.
REQ-025 If Tcount drops below a busy teller's index, that busy bit SHALL remain until its tellerDone; such a teller is not re-dispatched.
REQ-026 downSignal SHALL never be asserted on two consecutive cycles.

Reset
REQ-027 While reset=1 at a clock edge, the FSM SHALL go to IDLE, and the block SHALL clear the timeout counter, all busy bits and the frontSensor history, and point the round-robin pointer at teller 0.
REQ-028 On reset, outputs SHALL read downSignal=0, callValid=0, callTeller=0, ticketNo=0, noShow=0, tellerBusy=0.
REQ-029 Reset during CALL SHALL abandon the call without a downSignal pulse.

Structure
REQ-030 Shared package sbqm_pkg SHALL hold the FSM state enum, MAX_TELLERS=3 and TICKET_W=5.
REQ-031 Round-robin selection SHALL be a sub-module, teller_rr_arbiter (request mask in, one-hot grant plus index out, pointer update on accept).

Verification
REQ-032 Reset, Tcount=3, emptyFlag=0 -> the next cycle shows callValid=1, callTeller=1, ticketNo=1.
REQ-033 frontSensor pulse during CALL -> downSignal high exactly 1 cycle, then RELEASE, then the next call to teller 2 (ticketNo=2).
REQ-034 No frontSensor for 16 cycles in CALL -> noShow=1 and downSignal=1 in the same cycle, and tellerBusy for that teller is cleared.
REQ-035 Tcount=1 with teller 1 busy -> no call until tellerDone[0] pulses, then callTeller=1.
REQ-036 emptyFlag rises during CALL -> return to IDLE, downSignal stays 0, and 32 dispatches wrap ticketNo 31->0.

Source files
------------

// File: rtl/sbqm_pkg.sv
// Shared types and sizing for the service-queue dispatcher slice.
// The helper does modular index arithmetic for round-robin searches.
package sbqm_pkg;

    localparam int MAX_TELLERS = 3;
    localparam int TICKET_W    = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALL    = 2'd1,
        RELEASE = 2'd2
    } disp_state_t;

    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        while (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/teller_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr; ptr moves to one past the
// granted index only when the grant is accepted.
module teller_rr_arbiter
    import sbqm_pkg::*;
#(
    parameter int N = MAX_TELLERS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 accept,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[wrap_add(int'(ptr), k, N)]) begin
                valid = 1'b1;
                idx   = IW'(wrap_add(int'(ptr), k, N));
                grant[wrap_add(int'(ptr), k, N)] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept && valid) begin
            ptr <= IW'(wrap_add(int'(idx), 1, N));
        end
    end

endmodule

// File: rtl/teller_dispatcher.sv
// Calls the next waiting customer to a free teller desk, waits for the
// customer to pass the front sensor (or time out), then releases the display.
module teller_dispatcher
    import sbqm_pkg::*;
#(
    parameter int NUM_TELLERS    = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             Tcount,
    input  logic                   emptyFlag,
    input  logic [MAX_TELLERS-1:0] tellerDone,
    input  logic                   frontSensor,
    output logic                   downSignal,
    output logic                   callValid,
    output logic [1:0]             callTeller,
    output logic [TICKET_W-1:0]    ticketNo,
    output logic                   noShow,
    output logic [MAX_TELLERS-1:0] tellerBusy,
    output disp_state_t            dbgState
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    disp_state_t            state;
    logic [TW-1:0]          timer;
    logic                   fsPrev;
    logic [1:0]             curIdx;
    logic [MAX_TELLERS-1:0] req;
    logic [MAX_TELLERS-1:0] grant;
    logic [1:0]             grantIdx;
    logic                   grantValid;
    logic                   dispatch;
    logic                   fsRise;
    logic                   timerLast;
    logic [MAX_TELLERS-1:0] busyNext;

    assign dbgState  = state;
    assign fsRise    = frontSensor && !fsPrev;
    assign timerLast = (timer == TW'(TIMEOUT_CYCLES - 1));
    assign dispatch  = (state == IDLE) && !emptyFlag && (Tcount != 2'd0) && grantValid;

    // Teller i may be dispatched only when active, configured and free.
    always_comb begin
        req = '0;
        for (int i = 0; i < MAX_TELLERS; i++) begin
            if (i < NUM_TELLERS && 2'(i) < Tcount && !tellerBusy[i]) req[i] = 1'b1;
        end
    end

    teller_rr_arbiter #(.N(MAX_TELLERS)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .accept (dispatch),
        .grant  (grant),
        .idx    (grantIdx),
        .valid  (grantValid)
    );

    // The called desk ignores tellerDone; an abandoned or missed call frees it.
    always_comb begin
        busyNext = tellerBusy;
        for (int i = 0; i < MAX_TELLERS; i++) begin
            if (tellerDone[i] && !(state == CALL && curIdx == 2'(i))) busyNext[i] = 1'b0;
        end
        if (dispatch) busyNext = busyNext | grant;
        if (state == CALL && !fsRise && (emptyFlag || timerLast)) busyNext[curIdx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            fsPrev     <= 1'b0;
            curIdx     <= '0;
            downSignal <= 1'b0;
            callValid  <= 1'b0;
            callTeller <= '0;
            ticketNo   <= '0;
            noShow     <= 1'b0;
            tellerBusy <= '0;
        end else begin
            fsPrev     <= frontSensor;
            downSignal <= 1'b0;
            noShow     <= 1'b0;
            tellerBusy <= busyNext;
            case (state)
                IDLE: begin
                    if (dispatch) begin
                        state      <= CALL;
                        callValid  <= 1'b1;
                        callTeller <= grantIdx + 2'd1;
                        curIdx     <= grantIdx;
                        ticketNo   <= ticketNo + TICKET_W'(1);
                        timer      <= '0;
                    end
                end
                CALL: begin
                    if (fsRise) begin
                        state      <= RELEASE;
                        downSignal <= 1'b1;
                        callValid  <= 1'b0;
                        callTeller <= '0;
                    end else if (emptyFlag) begin
                        state      <= IDLE;
                        callValid  <= 1'b0;
                        callTeller <= '0;
                    end else if (timerLast) begin
                        state      <= RELEASE;
                        downSignal <= 1'b1;
                        noShow     <= 1'b1;
                        callValid  <= 1'b0;
                        callTeller <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
